// File: rtl/decoder_pipe_pkg.sv
// Shared opcode encodings, decoded-field layout and small helpers for the
// decoder_pipe instruction decoder.
package decoder_pipe_pkg;

    localparam logic [3:0] OP_WRITE = 4'b0111;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_EXT   = 4'b1111;

    localparam int PAYLOAD_W = 12;

    typedef struct packed {
        logic [3:0] opcode;
        logic [2:0] rd_select;
        logic       mode;
        logic [2:0] ra_select;
        logic [2:0] rb_select;
    } fields_t;

    // Opcodes whose 8-bit base immediate can be widened by a preceding EXT.
    function automatic logic takes_prefix(input logic [3:0] op);
        return (op == OP_WRITE) || (op == OP_LOAD) || (op == OP_JMP);
    endfunction

    function automatic fields_t slice_fields(input logic [15:0] instr);
        fields_t f;
        f.opcode    = instr[15:12];
        f.rd_select = instr[11:9];
        f.mode      = instr[8];
        f.ra_select = instr[7:5];
        f.rb_select = instr[4:2];
        return f;
    endfunction

endpackage

// File: rtl/decoder_pipe_imm_gen.sv
// Combinational immediate generator: base immediate per opcode, optionally
// widened with the upper bits held from a preceding EXT prefix.
module decoder_imm_gen
    import decoder_pipe_pkg::*;
#(
    parameter int IMM_WIDTH = 16
) (
    input  logic [3:0]           opcode_i,
    input  logic [15:0]          instruction_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    input  logic                 prefix_pending_i,
    output logic [IMM_WIDTH-1:0] immediate_o,
    output logic                 extended_o
);

    logic [7:0]           base_imm;
    logic signed [4:0]    short_imm;
    logic [IMM_WIDTH-1:0] prefixed_imm;
    logic                 unused_bits;

    // Opcode arrives separately; payload bits above IMM_WIDTH-8 never reach the output.
    assign unused_bits = ^{instruction_i[15:12], payload_i};

    assign short_imm = instruction_i[4:0];
    assign base_imm  = (opcode_i == OP_WRITE)
                     ? {instruction_i[11:9], instruction_i[2:0], 2'b00}
                     : instruction_i[7:0];

    generate
        if (IMM_WIDTH > 8) begin : g_prefix
            assign prefixed_imm = {payload_i[IMM_WIDTH-9:0], base_imm};
        end else begin : g_no_prefix
            assign prefixed_imm = IMM_WIDTH'(base_imm);
        end
    endgenerate

    always_comb begin
        immediate_o = IMM_WIDTH'(short_imm);
        extended_o  = 1'b0;
        if (takes_prefix(opcode_i)) begin
            if (prefix_pending_i) begin
                immediate_o = prefixed_imm;
                extended_o  = 1'b1;
            end else begin
                immediate_o = IMM_WIDTH'(base_imm);
            end
        end
    end

endmodule

// File: rtl/decoder_pipe.sv
// One-deep valid/ready instruction decoder with EXT immediate prefix and flush.
//   state    | meaning
//   S_IDLE   | no prefix held; next instruction decodes with its own immediate
//   S_PREFIX | EXT payload held; next WRITE/LOAD/JMP gets the upper immediate bits
module decoder_pipe
    import decoder_pipe_pkg::*;
#(
    parameter int IMM_WIDTH = 16
) (
    input  logic                 I_clk,
    input  logic                 I_reset,
    input  logic                 I_enable,
    input  logic                 I_flush,
    input  logic                 I_valid,
    output logic                 O_ready,
    input  logic [15:0]          I_instruction,
    output logic                 O_valid,
    input  logic                 I_ready,
    output logic [3:0]           O_opcode,
    output logic [2:0]           O_rD_select,
    output logic                 O_mode,
    output logic [2:0]           O_rA_select,
    output logic [2:0]           O_rB_select,
    output logic [IMM_WIDTH-1:0] O_immediate,
    output logic                 O_extended
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_PREFIX = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic                   valid_q, valid_d;
    fields_t                fields_q, fields_d;
    logic [IMM_WIDTH-1:0]   imm_q, imm_d;
    logic                   ext_q, ext_d;

    logic                   accept;
    logic                   is_ext;
    logic [IMM_WIDTH-1:0]   dec_imm;
    logic                   dec_ext;

    // I_ready feeds O_ready combinationally so a full register can refill in the emit cycle.
    assign O_ready = I_enable && !I_reset && !I_flush && (!valid_q || I_ready);
    assign accept  = I_valid && O_ready;
    assign is_ext  = (I_instruction[15:12] == OP_EXT);

    decoder_imm_gen #(
        .IMM_WIDTH (IMM_WIDTH)
    ) u_imm_gen (
        .opcode_i         (I_instruction[15:12]),
        .instruction_i    (I_instruction),
        .payload_i        (payload_q),
        .prefix_pending_i (state_q == S_PREFIX),
        .immediate_o      (dec_imm),
        .extended_o       (dec_ext)
    );

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        valid_d   = valid_q;
        fields_d  = fields_q;
        imm_d     = imm_q;
        ext_d     = ext_q;
        if (I_enable) begin
            if (I_flush) begin
                state_d   = S_IDLE;
                payload_d = '0;
                valid_d   = 1'b0;
            end else begin
                if (valid_q && I_ready) begin
                    valid_d = 1'b0;
                end
                if (accept) begin
                    if (is_ext) begin
                        payload_d = I_instruction[PAYLOAD_W-1:0];
                        state_d   = S_PREFIX;
                    end else begin
                        valid_d  = 1'b1;
                        fields_d = slice_fields(I_instruction);
                        imm_d    = dec_imm;
                        ext_d    = dec_ext;
                        state_d  = S_IDLE;
                    end
                end
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q   <= S_IDLE;
            payload_q <= '0;
            valid_q   <= 1'b0;
            fields_q  <= '0;
            imm_q     <= '0;
            ext_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            valid_q   <= valid_d;
            fields_q  <= fields_d;
            imm_q     <= imm_d;
            ext_q     <= ext_d;
        end
    end

    assign O_valid     = valid_q;
    assign O_opcode    = fields_q.opcode;
    assign O_rD_select = fields_q.rd_select;
    assign O_mode      = fields_q.mode;
    assign O_rA_select = fields_q.ra_select;
    assign O_rB_select = fields_q.rb_select;
    assign O_immediate = imm_q;
    assign O_extended  = ext_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe: accepted instructions push hand-computed
// expectations; a monitor compares every presented output beat in order.
module tb_decoder_pipe;

    localparam int IMM_WIDTH = 16;

    logic                 I_clk = 1'b0;
    logic                 I_reset, I_enable, I_flush, I_valid, I_ready;
    logic [15:0]          I_instruction;
    logic                 O_ready, O_valid, O_mode, O_extended;
    logic [3:0]           O_opcode;
    logic [2:0]           O_rD_select, O_rA_select, O_rB_select;
    logic [IMM_WIDTH-1:0] O_immediate;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] imm;
        logic        ext;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   beats  = 0;
    int   b0;

    decoder_pipe #(.IMM_WIDTH(IMM_WIDTH)) dut (
        .I_clk         (I_clk),
        .I_reset       (I_reset),
        .I_enable      (I_enable),
        .I_flush       (I_flush),
        .I_valid       (I_valid),
        .O_ready       (O_ready),
        .I_instruction (I_instruction),
        .O_valid       (O_valid),
        .I_ready       (I_ready),
        .O_opcode      (O_opcode),
        .O_rD_select   (O_rD_select),
        .O_mode        (O_mode),
        .O_rA_select   (O_rA_select),
        .O_rB_select   (O_rB_select),
        .O_immediate   (O_immediate),
        .O_extended    (O_extended)
    );

    always #5 I_clk = ~I_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [30:0] pack_exp(input exp_t e);
        return {e.instr[15:12], e.instr[11:9], e.instr[8], e.instr[7:5], e.instr[4:2], e.imm, e.ext};
    endfunction

    function automatic logic [30:0] observed();
        return {O_opcode, O_rD_select, O_mode, O_rA_select, O_rB_select, O_immediate, O_extended};
    endfunction

    // Monitor samples 1 time unit before each rising edge.
    always @(negedge I_clk) begin
        #4;
        if (O_valid) begin
            if (sb.size() == 0) begin
                chk("beat_has_expectation", O_valid, 0);
            end else begin
                chk("out_fields", observed(), pack_exp(sb[0]));
                if (I_ready && I_enable && !I_reset && !I_flush) begin
                    void'(sb.pop_front());
                    beats++;
                end
            end
        end
        if (I_reset || (I_flush && I_enable))
            sb.delete();
    end

    task automatic drive(input logic [15:0] instr, input logic [15:0] imm, input logic ext);
        bit acc = 0;
        @(negedge I_clk);
        I_valid       = 1'b1;
        I_instruction = instr;
        for (int n = 0; n < 50 && !acc; n++) begin
            if (n > 0) @(negedge I_clk);
            #4;
            acc = O_ready;
        end
        if (!acc)
            chk("accept_timeout", O_ready, 1);
        else if (instr[15:12] != 4'hF)
            sb.push_back('{instr, imm, ext});
    endtask

    task automatic idle();
        @(negedge I_clk);
        I_valid = 1'b0;
        #4;
    endtask

    task automatic drain();
        for (int n = 0; n < 50 && sb.size() != 0; n++) begin
            @(negedge I_clk);
            I_valid = 1'b0;
            #4;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    initial begin
        I_reset = 1'b1; I_enable = 1'b1; I_flush = 1'b0;
        I_valid = 1'b0; I_ready = 1'b1; I_instruction = 16'h0000;
        repeat (2) @(negedge I_clk);
        #4;
        chk("reset_ready", O_ready, 0);
        chk("reset_outputs", {O_valid, observed()}, 0);
        @(negedge I_clk);
        I_reset = 1'b0;
        #4;
        chk("post_reset_ready", O_ready, 1);

        // WRITE rD=5, instr[7:0]=06
        drive(16'h7A06, 16'h00B8, 1'b0);
        idle();
        chk("write_latency_valid", O_valid, 1);
        chk("write_rd", O_rD_select, 5);
        chk("write_ra", O_rA_select, 0);
        chk("write_rb", O_rB_select, 1);
        chk("write_mode", O_mode, 0);
        chk("write_imm", O_immediate, 16'h00B8);
        chk("write_ext", O_extended, 0);

        // sign-extended short immediates, back to back
        drive(16'h0573, 16'hFFF3, 1'b0);
        drive(16'h100A, 16'h000A, 1'b0);
        idle();
        drain();

        // EXT ABC then LOAD 5A: one beat, bubble after EXT
        b0 = beats;
        drive(16'hFABC, 16'h0000, 1'b0);
        @(negedge I_clk);
        I_valid = 1'b1;
        I_instruction = 16'h805A;
        #4;
        chk("bubble_after_ext", O_valid, 0);
        chk("load_after_ext_ready", O_ready, 1);
        sb.push_back('{16'h805A, 16'hBC5A, 1'b1});
        idle();
        drain();
        chk("ext_single_beat", beats - b0, 1);

        // JMP with prefix, EXT overwrite, prefix dropped by a plain opcode
        drive(16'hF0F1, 16'h0000, 1'b0);
        drive(16'hC080, 16'hF180, 1'b1);
        drive(16'hF111, 16'h0000, 1'b0);
        drive(16'hF022, 16'h0000, 1'b0);
        drive(16'h7203, 16'h222C, 1'b1);
        drive(16'hF0FF, 16'h0000, 1'b0);
        drive(16'h001F, 16'hFFFF, 1'b0);
        drive(16'h805A, 16'h005A, 1'b0);
        idle();
        drain();

        // backpressure with two queued instructions
        @(negedge I_clk);
        I_ready = 1'b0;
        b0 = beats;
        fork
            begin
                drive(16'h8011, 16'h0011, 1'b0);
                drive(16'h8022, 16'h0022, 1'b0);
            end
            begin
                bit seen = 0;
                for (int n = 0; n < 20 && !seen; n++) begin
                    @(negedge I_clk);
                    #4;
                    seen = O_valid;
                end
                chk("bp_valid_seen", O_valid, 1);
                repeat (3) begin
                    @(negedge I_clk);
                    #4;
                    chk("bp_ready_low", O_ready, 0);
                    chk("bp_valid_held", O_valid, 1);
                end
                @(negedge I_clk);
                I_ready = 1'b1;
            end
        join
        idle();
        drain();
        chk("bp_two_beats", beats - b0, 2);

        // flush drops a pending prefix and blocks the input that cycle
        drive(16'hF123, 16'h0000, 1'b0);
        @(negedge I_clk);
        I_flush = 1'b1;
        I_valid = 1'b1;
        I_instruction = 16'h8077;
        #4;
        chk("flush_blocks_accept", O_ready, 0);
        @(negedge I_clk);
        I_flush = 1'b0;
        I_valid = 1'b0;
        drive(16'h805A, 16'h005A, 1'b0);
        idle();
        drain();

        // flush wins over a simultaneous emit
        @(negedge I_clk);
        I_ready = 1'b0;
        drive(16'h8044, 16'h0044, 1'b0);
        idle();
        chk("pre_flush_valid", O_valid, 1);
        @(negedge I_clk);
        I_flush = 1'b1;
        I_ready = 1'b1;
        @(negedge I_clk);
        I_flush = 1'b0;
        #4;
        chk("flush_clears_valid", O_valid, 0);

        // enable low freezes output and ignores handshake
        @(negedge I_clk);
        I_ready = 1'b0;
        drive(16'h8055, 16'h0055, 1'b0);
        idle();
        @(negedge I_clk);
        I_enable = 1'b0;
        I_ready = 1'b1;
        I_valid = 1'b1;
        I_instruction = 16'h8066;
        b0 = beats;
        #4;
        chk("disabled_ready", O_ready, 0);
        @(negedge I_clk);
        #4;
        chk("disabled_hold_valid", O_valid, 1);
        chk("disabled_no_emit", beats - b0, 0);
        @(negedge I_clk);
        I_enable = 1'b1;
        I_valid = 1'b0;
        idle();
        drain();
        chk("enable_one_beat", beats - b0, 1);

        // reset with a valid output held
        @(negedge I_clk);
        I_ready = 1'b0;
        drive(16'h8033, 16'h0033, 1'b0);
        idle();
        @(negedge I_clk);
        I_reset = 1'b1;
        #4;
        chk("reset_ready_low", O_ready, 0);
        @(negedge I_clk);
        I_reset = 1'b0;
        I_ready = 1'b1;
        #4;
        chk("reset_clears_all", {O_valid, observed()}, 0);

        // reset while a prefix is pending
        drive(16'hF0AB, 16'h0000, 1'b0);
        @(negedge I_clk);
        I_reset = 1'b1;
        I_valid = 1'b0;
        @(negedge I_clk);
        I_reset = 1'b0;
        drive(16'h805A, 16'h005A, 1'b0);
        idle();
        chk("post_reset_load_imm", O_immediate, 16'h005A);
        chk("post_reset_load_ext", O_extended, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, handshaked instruction decoder that replaces the single-stage decoder between fetch and the register file/ALU. It splits a 16-bit instruction into opcode, register selects, mode bit and an IMM_WIDTH-bit immediate behind a one-deep valid/ready pipeline register. It adds an EXT prefix instruction that supplies upper immediate bits to the following instruction, plus flush support for jumps.

## Interface
- IMM_WIDTH, 16: width of O_immediate. Legal range 8..20.
- I_clk  in  1  clock
- I_reset  in  1  synchronous, active-high reset
- I_enable  in  1  global enable; 0 freezes the block (no accept, no output change)
- I_flush  in  1  discard pending prefix and output register
- I_valid  in  1  I_instruction is valid
- O_ready  out  1  block accepts I_instruction this cycle
- I_instruction  in  16  instruction word
- O_valid  out  1  decoded fields are valid
- I_ready  in  1  downstream consumes the output this cycle
- O_opcode  out  4  instr[15:12]
- O_rD_select  out  3  instr[11:9]
- O_mode  out  1  instr[8]
- O_rA_select  out  3  instr[7:5]
- O_rB_select  out  3  instr[4:2]
- O_immediate  out  IMM_WIDTH  immediate per rules below
- O_extended  out  1  the immediate carries EXT prefix bits

## Operation
- Accept: I_valid && O_ready at a rising edge. Emit: O_valid && I_ready.
- Base immediate (8 bits, b):
  - WRITE: b = {instr[11:9], instr[2:0], 2'b00}; zero-extended to IMM_WIDTH.
  - LOAD, JMP: b = instr[7:0]; zero-extended.
  - All other non-EXT opcodes: instr[4:0] sign-extended to IMM_WIDTH; the prefix is not applied.
- EXT (opcode 4'b1111): payload = instr[11:0]. It produces no output beat.
- FSM states: S_IDLE and S_PREFIX.
  - S_IDLE, accept EXT: store payload, go to S_PREFIX.
  - S_IDLE, accept other: emit with O_extended=0.
  - S_PREFIX, accept EXT: overwrite payload, stay in S_PREFIX.
  - S_PREFIX, accept WRITE/LOAD/JMP: O_immediate = {payload[IMM_WIDTH-9:0], b}, O_extended=1, go to S_IDLE.
  - S_PREFIX, accept other opcode: normal sign-extended immediate, O_extended=0, go to S_IDLE (prefix dropped).
  - If IMM_WIDTH==8 the prefix contributes no bits, but O_extended still follows the rules above.
- Register selects and mode are always raw bit slices, including for WRITE, LOAD and JMP.

## Timing
- Reset: state S_IDLE, payload 0, O_valid 0. All field outputs and O_extended are 0.
- Latency: 1 cycle from accept to O_valid.
- Ready: O_ready = I_enable && !I_reset && !I_flush && (!O_valid || I_ready). The path from I_ready to O_ready is combinational and documented.
- Throughput: 1 instruction/cycle under continuous I_ready. Any EXT costs one bubble.
- Output register: loads only on an accept of a non-EXT instruction.
  - On emit with no new load, O_valid drops to 0.
  - Field outputs are held whenever O_valid is 1 and I_ready is 0.
- I_flush (requires I_enable=1): at the next edge, O_valid is 0 and the FSM is in S_IDLE. The input in the flush cycle is not accepted. Flush wins over a simultaneous emit or accept.
- I_enable=0: all state holds, including O_valid. The I_ready handshake is ignored.
- Reset overrides everything, including I_enable=0, and takes effect at the next edge.

## Structure
- ops.vh gains EXT = 4'b1111. WRITE, LOAD and JMP come from the same header.
- FSM state encodings are localparams inside the module.
- Sub-module decoder_imm_gen is purely combinational.
  - Inputs: opcode, instruction, payload, prefix-pending.
  - Outputs: immediate and the extended flag.
  - Parameterised by IMM_WIDTH.
- The top level holds the FSM, payload register, output register and handshake.

## Test plan
- Reset, then WRITE with rD=3'b101 and instr[7:0]=8'h06, I_ready=1.
  - One cycle later: O_valid=1, O_rD_select=5, O_rA_select=0, O_rB_select=1, O_mode=0.
  - O_immediate=16'h00B8, O_extended=0.
- Non-special opcode with instr[4:0]=5'b10011 -> O_immediate=16'hFFF3.
- EXT payload 12'hABC, then LOAD imm 8'h5A back-to-back.
  - Exactly one output beat, O_immediate=16'hBC5A, O_extended=1.
  - O_valid is low in the cycle after the EXT accept.
- Backpressure: I_ready=0 for 3 cycles with two queued instructions.
  - First output is held stable and O_ready stays 0.
  - After I_ready=1, both instructions emerge in order with none lost.
- EXT 12'h123, then I_flush, then LOAD 8'h5A -> O_immediate=16'h005A, O_extended=0.
- I_reset during S_PREFIX while O_valid=1 -> next cycle O_valid=0, all outputs 0.
  - A following LOAD 8'h5A decodes as 16'h005A with O_extended=0.
